// File: rtl/load_store_unit_pkg.sv
// Shared types, byte-enable constants and request-decode helpers for the load/store unit.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    // Stores only know the three signed width codes; loads add the unsigned variants.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 inside {F3_B, F3_H, F3_W};
        end
        return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // size: funct3[1:0], 0 = byte, 1 = half, 2 = word.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return !addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] be_for(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return BE_W'(BE_BYTE << addr_lo);
            2'b01:   return BE_W'(BE_HALF << addr_lo);
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] wdata_for(input logic [1:0] size, input logic [XLEN-1:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction with sign/zero extension.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        result  = '0;
        case (funct3_e'(funct3))
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            F3_W:    result = rdata;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: decode, memory handshake, load alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned RegBits = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [2:0]         req_funct3_i,
    input  logic [RegBits-1:0] req_addr_i,
    input  logic [RegBits-1:0] req_wdata_i,
    output logic               resp_valid_o,
    output logic [RegBits-1:0] resp_rdata_o,
    output logic               resp_err_o,
    output logic               mem_req_o,
    input  logic               mem_gnt_i,
    output logic               mem_we_o,
    output logic [BE_W-1:0]    mem_be_o,
    output logic [RegBits-1:0] mem_addr_o,
    output logic [RegBits-1:0] mem_wdata_o,
    input  logic               mem_rvalid_i,
    input  logic [RegBits-1:0] mem_rdata_i
);

    state_e             state_q, state_d;
    logic [2:0]         funct3_q;
    logic [1:0]         addr_lo_q;
    logic               legal;
    logic               latch_req;
    logic               ready_d, mem_req_d, resp_valid_d, resp_err_d;
    logic [RegBits-1:0] resp_rdata_d;
    logic [RegBits-1:0] load_data;

    assign legal = is_legal(req_we_i, req_funct3_i)
                && is_aligned(req_funct3_i[1:0], req_addr_i[1:0]);

    lsu_load_align u_load_align (
        .rdata   (mem_rdata_i),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus next values of the registered handshake/response outputs.
    always_comb begin
        state_d      = state_q;
        latch_req    = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (legal) begin
                        state_d   = S_REQ;
                        latch_req = 1'b1;
                    end else begin
                        state_d    = S_RESP;
                        resp_err_d = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d      = S_RESP;
                    resp_rdata_d = mem_we_o ? '0 : load_data;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ready_d      = state_d == S_IDLE;
        mem_req_d    = state_d == S_REQ;
        resp_valid_d = state_d == S_RESP;
    end

    // Output registers; the memory-side request fields only change on accept, so they hold through REQ.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_ready_o  <= 1'b1;
            mem_req_o    <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= '0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
        end else begin
            req_ready_o  <= ready_d;
            mem_req_o    <= mem_req_d;
            resp_valid_o <= resp_valid_d;
            resp_err_o   <= resp_err_d;
            resp_rdata_o <= resp_rdata_d;
            if (latch_req) begin
                mem_we_o    <= req_we_i;
                mem_be_o    <= be_for(req_funct3_i[1:0], req_addr_i[1:0]);
                mem_addr_o  <= {req_addr_i[RegBits-1:2], 2'b00};
                mem_wdata_o <= wdata_for(req_funct3_i[1:0], req_wdata_i);
                funct3_q    <= req_funct3_i;
                addr_lo_q   <= req_addr_i[1:0];
            end
        end
    end

endmodule
